vedic_mac_acc: RTL and testbench

VEDIC_MAC_ACC -- requirements
Module: vedic_mac_acc

---
 rtl/vedic_mac_acc.sv | 100 ++++++++++
 tb/tb_vedic_mac_acc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mac_acc.sv
// Purpose: accumulates a job of `len` unsigned 16-bit products from an upstream vedic8x8 multiplier into an ACC_W-bit sum.
// Latency: one product per cycle in ACCUM; result valid the cycle after the final beat.
// Backpressure: prod_ready=0 outside ACCUM; in DONE the result and ovf hold until acc_ready. MAC_SATURATE_EN clamps on overflow instead of wrapping.
module vedic_mac_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    // Next-state logic: job capture, per-beat accumulate with carry detect, result handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        // One extra bit so the carry out of the add is visible as overflow.
        sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
                        // Once clamped, later adds carry again (or add 0), so it stays at all-ones.
                        acc_d = '1;
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready = (state_q == S_ACCUM);
    assign acc_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Bench: two instances (ACC_W=24 and ACC_W=16) driven by identical stimulus, checked every cycle
// against a job-level model (running total in wide arithmetic), plus literal expectations for
// the directed scenarios.
module tb_vedic_mac_acc;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [15:0]      prod = '0;
    logic             prod_valid = 1'b0;
    logic             acc_ready = 1'b0;

    logic        pr_a, av_a, busy_a, ovf_a;
    logic [23:0] acc_a;
    logic        pr_b, av_b, busy_b, ovf_b;
    logic [15:0] acc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vedic_mac_acc #(.ACC_W(24), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(pr_a), .acc_out(acc_a),
        .acc_valid(av_a), .acc_ready(acc_ready), .busy(busy_a), .ovf(ovf_a)
    );

    vedic_mac_acc #(.ACC_W(16), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(pr_b), .acc_out(acc_b),
        .acc_valid(av_b), .acc_ready(acc_ready), .busy(busy_b), .ovf(ovf_b)
    );

    // ---------------- behavioural model ----------------
    // Job phase: 0 idle, 1 collecting products, 2 result pending.
    int     m_phase = 0;
    int     m_rem = 0;
    longint m_total = 0;
    int     m_jobs_done = 0;
    bit     chk_en = 1'b0;

    function automatic logic [31:0] exp_acc(int w, longint total);
        longint lim;
        lim = 64'd1 << w;
        if (total < lim) return 32'(total);
`ifdef MAC_SATURATE_EN
        return 32'(lim - 1);
`else
        return 32'(total % lim);
`endif
    endfunction

    function automatic logic exp_ovf(int w, longint total);
        return total >= (64'd1 << w);
    endfunction

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (!rst_n) begin
            m_phase = 0;
            m_rem   = 0;
            m_total = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_rem   = int'(len);
                    m_total = 0;
                    m_phase = (len == 0) ? 2 : 1;
                end
                1: if (prod_valid) begin
                    m_total = m_total + longint'(prod);
                    m_rem   = m_rem - 1;
                    if (m_rem == 0) m_phase = 2;
                end
                default: if (acc_ready) begin
                    m_phase = 0;
                    m_jobs_done++;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a.prod_ready", 32'(pr_a),   32'(m_phase == 1));
            check("a.acc_valid",  32'(av_a),   32'(m_phase == 2));
            check("a.busy",       32'(busy_a), 32'(m_phase != 0));
            check("a.acc_out",    32'(acc_a),  exp_acc(24, m_total));
            check("a.ovf",        32'(ovf_a),  32'(exp_ovf(24, m_total)));
            check("b.prod_ready", 32'(pr_b),   32'(m_phase == 1));
            check("b.acc_valid",  32'(av_b),   32'(m_phase == 2));
            check("b.busy",       32'(busy_b), 32'(m_phase != 0));
            check("b.acc_out",    32'(acc_b),  exp_acc(16, m_total));
            check("b.ovf",        32'(ovf_b),  32'(exp_ovf(16, m_total)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_job(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] p);
        prod_valid = 1'b1;
        prod       = p;
        cyc();
        prod_valid = 1'b0;
    endtask

    task automatic release_result();
        acc_ready = 1'b1;
        cyc();
        acc_ready = 1'b0;
    endtask

    initial begin
        cyc(2);
        check("rst.busy",  32'(busy_a), 32'h0);
        check("rst.acc",   32'(acc_a),  32'h0);
        rst_n = 1'b1;
        cyc();

        // Basic job: 3 x 0xFE01.
        begin_job(3);
        beat(16'hFE01); beat(16'hFE01); beat(16'hFE01);
        check("basic.valid", 32'(av_a),  32'h1);
        check("basic.acc",   32'(acc_a), 32'h02FA03);
        check("basic.ovf",   32'(ovf_a), 32'h0);
        release_result();
        check("basic.idle_hold", 32'(acc_a), 32'h02FA03);

        // Empty job.
        begin_job(0);
        check("empty.valid", 32'(av_a),  32'h1);
        check("empty.acc",   32'(acc_a), 32'h0);
        release_result();

        // Gaps, then backpressure with ignored start pulses.
        begin_job(2);
        beat(16'h0010);
        cyc(2);
        beat(16'h0020);
        check("gap.acc", 32'(acc_a), 32'h30);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            len   = 8'd7;
            cyc();
        end
        check("bp.valid", 32'(av_a),  32'h1);
        check("bp.acc",   32'(acc_a), 32'h30);
        start = 1'b1;
        acc_ready = 1'b1;
        cyc();
        start = 1'b0;
        acc_ready = 1'b0;
        check("bp.start_ignored", 32'(busy_a), 32'h0);
        cyc();

        // Overflow on the 16-bit instance.
        begin_job(2);
        beat(16'hFFFF); beat(16'h0002);
`ifdef MAC_SATURATE_EN
        check("ovf.acc16", 32'(acc_b), 32'hFFFF);
`else
        check("ovf.acc16", 32'(acc_b), 32'h0001);
`endif
        check("ovf.flag16", 32'(ovf_b), 32'h1);
        check("ovf.acc24",  32'(acc_a), 32'h10001);
        release_result();

        // Reset mid-job.
        begin_job(4);
        beat(16'h1234); beat(16'h1234);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rst_mid.busy",  32'(busy_a), 32'h0);
        check("rst_mid.acc",   32'(acc_a),  32'h0);
        check("rst_mid.ready", 32'(pr_a),   32'h0);
        begin_job(1);
        beat(16'h0005);
        check("after_rst.acc", 32'(acc_a), 32'h5);
        check("after_rst.ovf", 32'(ovf_a), 32'h0);
        release_result();

        // Random traffic: all inputs randomized every cycle, rare resets.
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            len        = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 255))
                                                      : CNT_W'($urandom_range(0, 6));
            prod       = 16'($urandom);
            prod_valid = ($urandom_range(0, 3) != 0);
            acc_ready  = ($urandom_range(0, 2) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            cyc();
        end
        start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; rst_n = 1'b1;
        cyc(2);
        checks++;
        if (m_jobs_done < 20) begin
            errors++;
            $display("FAIL rand.jobs_completed got %0d expected >= 20", m_jobs_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
